vrased_reset_ctrl: RTL

Central violation-reset sequencer for the VRASED hardware monitors. It collects violation requests from the access/stack/atomicity monitors, drives one stretched system reset to the MSP430 core, and holds the platform in a recovery phase until the core fetches the reset vector cleanly. It also latches which monitors fired and counts violation events for post-mortem inspection by trusted code.

---
 rtl/vrased_reset_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/vrased_reset_ctrl.sv
// Violation-reset sequencer: collects monitor violations, stretches one reset to the core,
// then waits for a clean reset-vector fetch before returning to idle.
module vrased_reset_ctrl #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned WAIT_MAX      = 64,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_viol,
    input  logic [15:0]      i_pc,
    input  logic             i_cause_clr,
    output logic             o_sys_rst,
    output logic [1:0]       o_ctrl_state,
    output logic [N_SRC-1:0] o_cause,
    output logic [N_SRC-1:0] o_first_cause,
    output logic [CNT_W-1:0] o_viol_cnt
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAssert  = 2'b01,
        StRelease = 2'b10
    } state_e;

    localparam logic [7:0]       HoldReload = 8'(HOLD_CYCLES - 1);
    localparam logic [9:0]       WaitLast   = 10'(WAIT_MAX - 1);
    localparam logic [N_SRC-1:0] SrcOne     = N_SRC'(1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           r_state;
    logic             r_sys_rst;
    logic [7:0]       r_hold_cnt;
    logic [9:0]       r_wait_cnt;
    logic [N_SRC-1:0] r_cause;
    logic [N_SRC-1:0] r_first_cause;
    logic [CNT_W-1:0] r_viol_cnt;

    logic             w_any;
    logic [N_SRC-1:0] w_lowest;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_any     = |i_viol;
    // Two's-complement trick isolates the lowest set bit.
    assign w_lowest  = i_viol & (~i_viol + SrcOne);
    assign w_cnt_inc = (r_viol_cnt == '1) ? r_viol_cnt : r_viol_cnt + CntOne;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_sys_rst     <= 1'b0;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_cause       <= '0;
            r_first_cause <= '0;
            r_viol_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_sys_rst <= 1'b0;
                    if (w_any) begin
                        r_state       <= StAssert;
                        r_sys_rst     <= 1'b1;
                        r_hold_cnt    <= HoldReload;
                        r_cause       <= i_cause_clr ? i_viol : (r_cause | i_viol);
                        r_first_cause <= w_lowest;
                        r_viol_cnt    <= w_cnt_inc;
                    end else if (i_cause_clr) begin
                        r_cause <= '0;
                    end
                end
                StAssert: begin
                    if (w_any) begin
                        r_cause    <= r_cause | i_viol;
                        r_hold_cnt <= HoldReload;
                    end else if (r_hold_cnt != 8'd0) begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end else begin
                        r_state    <= StRelease;
                        r_sys_rst  <= 1'b0;
                        r_wait_cnt <= '0;
                    end
                end
                StRelease: begin
                    if (w_any) begin
                        r_state    <= StAssert;
                        r_sys_rst  <= 1'b1;
                        r_hold_cnt <= HoldReload;
                        r_cause    <= r_cause | i_viol;
                        r_viol_cnt <= w_cnt_inc;
                    end else if (i_pc == RESET_HANDLER) begin
                        r_state <= StIdle;
                    end else if (r_wait_cnt == WaitLast) begin
                        // Core never reached the reset vector: re-assert without a new event.
                        r_state    <= StAssert;
                        r_sys_rst  <= 1'b1;
                        r_hold_cnt <= HoldReload;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 10'd1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_sys_rst <= 1'b0;
                end
            endcase
        end
    end

    assign o_sys_rst     = r_sys_rst;
    assign o_ctrl_state  = r_state;
    assign o_cause       = r_cause;
    assign o_first_cause = r_first_cause;
    assign o_viol_cnt    = r_viol_cnt;

endmodule
